audio_rate_ctrl: RTL and testbench
==================================

Name: audio_rate_ctrl

Overview:
- Controls the audio master-clock divider chain. Derives sclk (64fs) and lrck (fs) from mclk at one of three selectable mclk/fs ratios.
- Sequences glitch-free rate changes:
  - mutes the downstream codec/AES/I2S consumers through a request/acknowledge handshake;
  - stops the clocks on a frame boundary, reloads the ratio and restarts;
  - lets the clocks settle, then unmutes.
- Sits between the mclk source and all sclk/lrck consumers.

Parameters:
- INIT_RATE, 2'd1, rate code loaded at reset (0, 1 or 2).
- MUTE_TIMEOUT, 16'd4096, mclk cycles to wait for mute_ack before forcing the change.
- SETTLE_FRAMES, 4, complete lrck frames run muted after restart (1..15).

Ports:
- mclk  in  1  master audio clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- rate_sel  in  2  requested rate code: 0 = 512fs, 1 = 256fs, 2 = 128fs, 3 = invalid.
- rate_req  in  1  one-cycle strobe that samples rate_sel.
- mute_ack  in  1  level, high while consumers are muted.
- sclk  out  1  bit clock, 64fs.
- lrck  out  1  frame clock, fs, 50% duty.
- clk_en  out  1  high while sclk/lrck are toggling.
- mute_req  out  1  level mute request to consumers.
- rate_busy  out  1  high whenever a change is in progress.
- cur_rate  out  2  active rate code.
- rate_done  out  1  one-cycle pulse when a change completes.
- rate_err  out  1  one-cycle pulse on an invalid request or a mute timeout.

Behaviour:
- Reset values:
  - frame counter cnt = 0, state RUN, cur_rate = INIT_RATE, clk_en = 1;
  - sclk = lrck = 0;
  - mute_req, rate_busy, rate_done, rate_err = 0.
- Frame counter, 9 bits, increments every mclk while clk_en = 1. Wraps at frame length L − 1, where L = 512, 256 or 128 for codes 0, 1, 2.
- Output taps, registered decode of cnt, zero latency relative to cnt:
  - code 0: sclk = cnt[2], lrck = cnt[8];
  - code 1: sclk = cnt[1], lrck = cnt[7];
  - code 2: sclk = cnt[0], lrck = cnt[6].
- While clk_en = 0: cnt held at 0, sclk = lrck = 0.
- "Wrap" means cnt == L − 1 while clk_en = 1.
- FSM:
  - RUN: rate_busy = 0, mute_req = 0. On rate_req:
    - sel == 3: pulse rate_err, stay in RUN.
    - sel == cur_rate: pulse rate_done, stay in RUN.
    - otherwise: latch sel into pend, set mute_req, clear the timeout counter, go to MUTE_WAIT.
  - MUTE_WAIT: rate_busy = 1, mute_req = 1. The timeout counter increments each cycle.
    - mute_ack high sets flag go.
    - Timeout counter reaching MUTE_TIMEOUT − 1 sets go and pulses rate_err once.
    - With go set, the next wrap moves to STOP. That cycle clk_en drops, cnt forces to 0 and sclk/lrck go 0.
  - STOP: exactly one cycle. cur_rate <= pend. Go to SETTLE with clk_en = 1; cnt restarts from 0 in the new mode.
  - SETTLE: mute_req stays 1. Count wraps; after SETTLE_FRAMES wraps go to UNMUTE.
  - UNMUTE: one cycle. mute_req <= 0, pulse rate_done, go to RUN.
- Further requests:
  - rate_req while not in RUN is ignored, with no error.
  - rate_req in the same cycle as the UNMUTE→RUN transition is also ignored.
- If mute_ack deasserts during MUTE_WAIT after go is set, go stays set.
- cur_rate changes only in STOP. sclk/lrck never show a pulse shorter than half a period of either the old or the new mode.
- Asserting rst_n mid-change aborts immediately to the reset values. cur_rate returns to INIT_RATE and mute_req drops.

Test Plan:
- Reset release, INIT_RATE = 1, no requests → clk_en = 1; lrck rises after 128 mclk and has period 256; sclk has period 4; rate_busy = 0.
- rate_req with sel = 0, mute_ack raised 10 cycles after mute_req →
  - STOP falls at the next wrap, with sclk/lrck low for 1 cycle;
  - then lrck period 512 and sclk period 8;
  - rate_done fires after 4 × 512 cycles;
  - cur_rate = 0.
- rate_req with sel = 3, and separately sel == cur_rate → single rate_err pulse and single rate_done pulse respectively; mute_req never asserts.
- mute_ack tied low, MUTE_TIMEOUT = 16 → rate_err pulses in cycle 16 of MUTE_WAIT; the change then completes normally to sel = 2 (lrck period 128).
- Second rate_req issued during SETTLE → ignored; rate_busy stays 1; cur_rate equals the first request.
- rst_n pulsed low during SETTLE → immediately mute_req = 0, cur_rate = INIT_RATE, cnt = 0; normal running resumes.

Source files
------------

// File: rtl/audio_rate_ctrl.sv
// Audio master-clock divider: derives sclk (64fs) and lrck (fs) from mclk and
// sequences muted, frame-aligned, glitch-free changes of the mclk/fs ratio.
module audio_rate_ctrl #(
  parameter logic [1:0]  INIT_RATE     = 2'd1,
  parameter logic [15:0] MUTE_TIMEOUT  = 16'd4096,
  parameter int          SETTLE_FRAMES = 4
) (
  input  logic       mclk,
  input  logic       rst_n,
  input  logic [1:0] rate_sel,
  input  logic       rate_req,
  input  logic       mute_ack,
  output logic       sclk,
  output logic       lrck,
  output logic       clk_en,
  output logic       mute_req,
  output logic       rate_busy,
  output logic [1:0] cur_rate,
  output logic       rate_done,
  output logic       rate_err
);

  localparam logic [2:0] ST_RUN       = 3'd0;
  localparam logic [2:0] ST_MUTE_WAIT = 3'd1;
  localparam logic [2:0] ST_STOP      = 3'd2;
  localparam logic [2:0] ST_SETTLE    = 3'd3;
  localparam logic [2:0] ST_UNMUTE    = 3'd4;

  // The timeout pulse is registered one cycle ahead so rate_err is high in the
  // cycle the counter reaches MUTE_TIMEOUT-1 (MUTE_TIMEOUT must be >= 2).
  localparam logic [15:0] TMO_PRE     = MUTE_TIMEOUT - 16'd2;
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_FRAMES - 1);

  logic [2:0]  state, state_nxt;
  logic [8:0]  cnt, cnt_nxt, cnt_last;
  logic [1:0]  pend, rate_nxt;
  logic [15:0] tmo;
  logic [3:0]  frames;
  logic        go, busy;
  logic        wrap, clk_en_nxt, sclk_nxt, lrck_nxt;
  logic        req_bad, req_same, req_new, tmo_hit, stop_now;
  logic [1:0]  taps;

  function automatic logic [8:0] frame_last(input logic [1:0] r);
    logic [8:0] v;
    case (r)
      2'd0:    v = 9'd511;
      2'd1:    v = 9'd255;
      default: v = 9'd127;
    endcase
    return v;
  endfunction

  // Returns {lrck, sclk} for a given count and rate code.
  function automatic logic [1:0] tap_decode(input logic [8:0] c, input logic [1:0] r);
    logic [1:0] v;
    case (r)
      2'd0:    v = {c[8], c[2]};
      2'd1:    v = {c[7], c[1]};
      default: v = {c[6], c[0]};
    endcase
    return v;
  endfunction

  always_comb begin
    cnt_last = frame_last(cur_rate);
    wrap     = clk_en && (cnt == cnt_last);
    req_bad  = (state == ST_RUN) && rate_req && (rate_sel == 2'd3);
    req_same = (state == ST_RUN) && rate_req && (rate_sel != 2'd3) && (rate_sel == cur_rate);
    req_new  = (state == ST_RUN) && rate_req && (rate_sel != 2'd3) && (rate_sel != cur_rate);
    tmo_hit  = (state == ST_MUTE_WAIT) && !go && !mute_ack && (tmo == TMO_PRE);
    stop_now = (state == ST_MUTE_WAIT) && go && wrap;

    clk_en_nxt = clk_en;
    if (stop_now)
      clk_en_nxt = 1'b0;
    else if (state == ST_STOP)
      clk_en_nxt = 1'b1;

    rate_nxt = (state == ST_STOP) ? pend : cur_rate;
    cnt_nxt  = (!clk_en || !clk_en_nxt || wrap) ? 9'd0 : cnt + 9'd1;

    // Taps are decoded from the next count so sclk/lrck line up with cnt.
    taps     = clk_en_nxt ? tap_decode(cnt_nxt, rate_nxt) : 2'b00;
    lrck_nxt = taps[1];
    sclk_nxt = taps[0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:       if (req_new) state_nxt = ST_MUTE_WAIT;
      ST_MUTE_WAIT: if (stop_now) state_nxt = ST_STOP;
      ST_STOP:      state_nxt = ST_SETTLE;
      ST_SETTLE:    if (wrap && (frames == SETTLE_LAST)) state_nxt = ST_UNMUTE;
      ST_UNMUTE:    state_nxt = ST_RUN;
      default:      state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      cnt       <= 9'd0;
      clk_en    <= 1'b1;
      sclk      <= 1'b0;
      lrck      <= 1'b0;
      cur_rate  <= INIT_RATE;
      pend      <= INIT_RATE;
      tmo       <= 16'd0;
      go        <= 1'b0;
      frames    <= 4'd0;
      busy      <= 1'b0;
      rate_done <= 1'b0;
      rate_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      clk_en    <= clk_en_nxt;
      sclk      <= sclk_nxt;
      lrck      <= lrck_nxt;
      cur_rate  <= rate_nxt;
      busy      <= (state_nxt != ST_RUN);
      rate_done <= req_same || (state == ST_UNMUTE);
      rate_err  <= req_bad || tmo_hit;

      if (req_new) begin
        pend <= rate_sel;
        tmo  <= 16'd0;
        go   <= 1'b0;
      end else if (state == ST_MUTE_WAIT) begin
        if (!go) tmo <= tmo + 16'd1;
        if (mute_ack || tmo_hit) go <= 1'b1;
      end

      if (state == ST_STOP)
        frames <= 4'd0;
      else if ((state == ST_SETTLE) && wrap)
        frames <= frames + 4'd1;
    end
  end

  assign mute_req  = busy;
  assign rate_busy = busy;

endmodule

// File: tb/tb_audio_rate_ctrl.sv
// Scoreboard bench for audio_rate_ctrl: a timeline model predicts clock
// waveforms, mute level and done/err pulses; a monitor compares every cycle.
module tb_audio_rate_ctrl;

  localparam logic [1:0]  INIT = 2'd1;
  localparam logic [15:0] MT   = 16'd16;
  localparam int          SF   = 4;

  logic       mclk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] rate_sel = 2'd0;
  logic       rate_req = 1'b0;
  logic       mute_ack = 1'b0;
  logic       sclk, lrck, clk_en, mute_req, rate_busy, rate_done, rate_err;
  logic [1:0] cur_rate;

  audio_rate_ctrl #(.INIT_RATE(INIT), .MUTE_TIMEOUT(MT), .SETTLE_FRAMES(SF)) dut (
    .mclk(mclk), .rst_n(rst_n), .rate_sel(rate_sel), .rate_req(rate_req),
    .mute_ack(mute_ack), .sclk(sclk), .lrck(lrck), .clk_en(clk_en),
    .mute_req(mute_req), .rate_busy(rate_busy), .cur_rate(cur_rate),
    .rate_done(rate_done), .rate_err(rate_err)
  );

  always #5 mclk = ~mclk;

  // Timeline segments: from cycle 'from' on, clocks run with phase origin t0.
  typedef struct {int from; int t0; int rate; bit muted; bit stopped;} seg_t;
  typedef struct {int cyc; bit is_err;} ev_t;

  seg_t seg_q[$];
  ev_t  ev_q[$];
  int   cyc;
  int   vectors = 0;
  int   miscompares = 0;
  int   m_rate;
  int   m_t0;

  always @(posedge mclk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  always @(negedge mclk) begin : mon
    seg_t sg;
    ev_t  e;
    int   len, ph;
    logic exp_s, exp_l, exp_en;
    if (rst_n && seg_q.size() > 0) begin
      while (seg_q.size() > 1 && seg_q[1].from <= cyc) void'(seg_q.pop_front());
      sg = seg_q[0];
      if (sg.stopped) begin
        exp_en = 1'b0; exp_s = 1'b0; exp_l = 1'b0;
      end else begin
        len    = 512 >> sg.rate;
        ph     = (cyc - sg.t0) % len;
        exp_en = 1'b1;
        exp_l  = (ph >= len / 2);
        exp_s  = ((ph % (len / 64)) >= (len / 128));
      end
      chk("clk_en", clk_en, exp_en);
      chk("sclk", sclk, exp_s);
      chk("lrck", lrck, exp_l);
      chk("mute_req", mute_req, sg.muted);
      chk("rate_busy", rate_busy, sg.muted);
      chk("cur_rate", cur_rate, sg.rate);
      while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
        chk("pulse_missing_at", cyc, ev_q[0].cyc);
        void'(ev_q.pop_front());
      end
      if (rate_done || rate_err) begin
        if (ev_q.size() == 0) chk("pulse_unexpected", {30'd0, rate_err, rate_done}, 0);
        else begin
          e = ev_q.pop_front();
          chk("pulse_cyc", cyc, e.cyc);
          chk("pulse_err", rate_err, e.is_err);
          chk("pulse_done", rate_done, !e.is_err);
        end
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge mclk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_mute_req", mute_req, 0);
    chk("rst_rate_busy", rate_busy, 0);
    chk("rst_cur_rate", cur_rate, INIT);
    chk("rst_clk_en", clk_en, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_lrck", lrck, 0);
    chk("rst_done", rate_done, 0);
    chk("rst_err", rate_err, 0);
    mute_ack = 1'b0;
    rate_req = 1'b0;
    ev_q.delete();
    seg_q.delete();
    seg_q.push_back(seg_t'{0, 0, INIT, 1'b0, 1'b0});
    m_rate = INIT;
    m_t0   = 0;
    repeat (3) @(negedge mclk);
    rst_n = 1'b1;
  endtask

  // Issued at a negedge; rate_req is visible to the DUT in cycle tr.
  task automatic req(input logic [1:0] sel, input int ack_dly, input bit ack_en,
                     input int ack_w, input bit extra, input bit rst_mid);
    int tr, len, ta, g, s, t0n, done_c;
    bit tmo;
    tr = cyc;
    rate_sel = sel;
    rate_req = 1'b1;
    if (sel == 2'd3) ev_q.push_back(ev_t'{tr + 1, 1'b1});
    else if (int'(sel) == m_rate) ev_q.push_back(ev_t'{tr + 1, 1'b0});
    else begin
      len    = 512 >> m_rate;
      ta     = tr + 1 + ack_dly;
      tmo    = !(ack_en && ta <= tr + int'(MT) - 1);
      g      = tmo ? tr + int'(MT) : ta + 1;
      s      = g + (len - 1 - ((g - m_t0) % len));
      t0n    = s + 2;
      done_c = t0n + SF * (512 >> sel) + 1;
      seg_q.push_back(seg_t'{tr + 1, m_t0, m_rate, 1'b1, 1'b0});
      seg_q.push_back(seg_t'{s + 1, m_t0, m_rate, 1'b1, 1'b1});
      seg_q.push_back(seg_t'{t0n, t0n, int'(sel), 1'b1, 1'b0});
      if (tmo) ev_q.push_back(ev_t'{tr + int'(MT), 1'b1});
      if (!rst_mid) begin
        seg_q.push_back(seg_t'{done_c, t0n, int'(sel), 1'b0, 1'b0});
        ev_q.push_back(ev_t'{done_c, 1'b0});
      end
    end
    @(negedge mclk);
    rate_req = 1'b0;
    rate_sel = 2'($urandom);
    if (sel == 2'd3 || int'(sel) == m_rate) begin
      wait_cyc(tr + 4);
      return;
    end
    if (ack_en) begin
      wait_cyc(ta);
      mute_ack = 1'b1;
      if (ack_w > 0) begin
        wait_cyc(ta + ack_w);
        mute_ack = 1'b0;
      end
    end
    if (extra) begin
      wait_cyc(t0n + 5 + $urandom_range(0, 512 >> sel));
      rate_sel = 2'($urandom);
      rate_req = 1'b1;
      @(negedge mclk);
      rate_req = 1'b0;
    end
    if (rst_mid) begin
      wait_cyc(t0n + 100);
      do_reset();
      return;
    end
    wait_cyc(done_c + 1);
    mute_ack = 1'b0;
    m_rate = int'(sel);
    m_t0   = t0n;
    wait_cyc(done_c + 3 + $urandom_range(0, 40));
  endtask

  initial begin
    #1;
    do_reset();
    wait_cyc(600);
    req(2'd0, 10, 1'b1, 0, 1'b0, 1'b0);
    req(2'd3, 0, 1'b0, 0, 1'b0, 1'b0);
    req(2'd0, 0, 1'b0, 0, 1'b0, 1'b0);
    req(2'd2, 0, 1'b0, 0, 1'b0, 1'b0);
    req(2'd1, 5, 1'b1, 2, 1'b1, 1'b0);
    req(2'd0, 3, 1'b1, 0, 1'b0, 1'b1);
    wait_cyc(300);
    for (int i = 0; i < 8; i++) begin
      req(2'($urandom_range(0, 3)), $urandom_range(0, 25), ($urandom_range(0, 4) != 0),
          $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end
    wait_cyc(cyc + 50);
    chk("pending_events", ev_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog at cyc %0d: run did not finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
